gate_bist_ctrl: RTL and testbench
=================================

Name: gate_bist_ctrl

Overview:
- Parametrised built-in self-test controller for the simulator gate-library netlists: 22-input/10-output models and any other width.
- Drives the combinational gate model under test with a Galois LFSR pattern stream for a programmable number of cycles.
- Compacts the model outputs into a MISR signature and compares the result against an expected golden value.
- Sits beside one gate model in the lab simulator and replaces hand-driven stimulus.

Parameters:
- IN_W, 22, width of LFSR and dut_in (≥2).
- OUT_W, 10, width of MISR, dut_out, signature (≥2).
- CNT_W, 16, width of pattern counter and num_pat.
- POLY, 22'h300000, Galois LFSR feedback mask, IN_W bits (x^22+x^21+1).
- MPOLY, 10'h240, Galois MISR feedback mask, OUT_W bits (x^10+x^7+1).
- SEED, 1, LFSR load value at start; 0 is replaced by 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle start request
- num_pat  in  CNT_W  patterns to apply, sampled at accepted start
- golden  in  OUT_W  expected signature, sampled at accepted start
- dut_in  out  IN_W  pattern to gate model inputs
- dut_out  in  OUT_W  gate model outputs, combinational from dut_in
- busy  out  1  high in RUN
- done  out  1  high in DONE
- signature  out  OUT_W  MISR contents
- pass  out  1  done && signature==golden_reg
- pat_cnt  out  CNT_W  patterns applied so far

Behaviour:
- One clock; reset is synchronous and active-high (rst sampled on rising clk).
- Reset values: state IDLE; lfsr, misr, pat_cnt, golden_reg = 0. Outputs: dut_in=0, busy=0, done=0, signature=0, pass=0, pat_cnt=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → lfsr=SEED (or 1 if SEED==0), misr=0, pat_cnt=0, latch num_pat and golden.
    - If num_pat==0 → DONE directly, signature 0.
    - Otherwise → RUN.
  - RUN, each cycle:
    - dut_in=lfsr.
    - misr <= step(misr, MPOLY) ^ dut_out.
    - lfsr <= step(lfsr, POLY).
    - pat_cnt <= pat_cnt+1.
    - When pat_cnt+1 == num_pat_reg → DONE.
    - start is ignored in RUN.
  - DONE: signature and pass held, dut_in=0.
    - start=1 → restart exactly as from IDLE, same cycle semantics.
    - Otherwise the block stays in DONE.
- step(x,P): if x[0] then (x>>1)^P else x>>1.
- Latency: applying N patterns takes N cycles of busy. done rises on the clock edge after the last pattern is applied.
- dut_in is registered (lfsr) and is 0 outside RUN. dut_out is sampled in the same cycle it is produced.
- LFSR never reaches 0 (nonzero seed, primitive POLY is the user's responsibility). The counter does not wrap, because num_pat ≤ 2^CNT_W−1.
- rst mid-RUN: the block returns to the reset state on the next edge and the partial signature is discarded.
- start and rst asserted together: rst wins.

Optional Feature:
- Macro: GATE_BIST_HOLD_EN.
- With the macro: an extra input port hold (1 bit) is added. In RUN, hold=1 freezes lfsr, misr and pat_cnt; dut_in keeps its value and busy stays 1. In IDLE/DONE, hold is ignored.
- Without the macro: the port does not exist and RUN advances every cycle.

Test Plan:
- rst, then start with num_pat=2, dut_out tied 3FF → dut_in 0x000001 then 0x300000; signature 0x040; with golden=0x040 → pass=1, done=1, busy high exactly 2 cycles.
- start with num_pat=1, dut_out=3FF, golden=0x000 → signature 0x3FF, pass=0.
- dut_out tied 0, num_pat=1000 → signature 0x000, pat_cnt=1000, done asserted after 1000 busy cycles.
- start with num_pat=0 → done on next edge, busy never 1, signature 0, pass = (golden==0).
- rst pulse at pattern 5 of 20 → all outputs 0 next cycle, state IDLE. A second start during RUN is ignored; start in DONE restarts with dut_in=SEED.
- GATE_BIST_HOLD_EN: hold for 3 cycles mid-run with num_pat=4 → busy lasts 7 cycles and the signature is identical to the unheld run.

Source files
------------

// File: rtl/gate_bist_ctrl.sv
// LFSR-driven BIST controller with MISR compaction for one gate model.
// Define GATE_BIST_HOLD_EN to add a hold input that pauses a running test.
module gate_bist_ctrl #(
    parameter int              IN_W  = 22,
    parameter int              OUT_W = 10,
    parameter int              CNT_W = 16,
    parameter logic [IN_W-1:0] POLY  = 22'h300000,
    parameter logic [OUT_W-1:0] MPOLY = 10'h240,
    parameter logic [IN_W-1:0] SEED  = IN_W'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef GATE_BIST_HOLD_EN
    input  logic             hold,
`endif
    input  logic [CNT_W-1:0] num_pat,
    input  logic [OUT_W-1:0] golden,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] signature,
    output logic             pass,
    output logic [CNT_W-1:0] pat_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    // A zero seed would lock the LFSR, so it is forced to 1.
    localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;

    function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] x);
        return x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
    endfunction

    function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] x);
        return x[0] ? ((x >> 1) ^ MPOLY) : (x >> 1);
    endfunction

    state_e           state_q, state_d;
    logic [IN_W-1:0]  lfsr_q, lfsr_d;
    logic [OUT_W-1:0] misr_q, misr_d;
    logic [CNT_W-1:0] pat_cnt_q, pat_cnt_d;
    logic [CNT_W-1:0] num_pat_q, num_pat_d;
    logic [OUT_W-1:0] golden_q, golden_d;

    logic adv;
    logic load;
    logic last;

`ifdef GATE_BIST_HOLD_EN
    assign adv = ~hold;
`else
    assign adv = 1'b1;
`endif

    assign load = start && (state_q != S_RUN);
    assign last = (pat_cnt_q + CNT_W'(1)) == num_pat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lfsr_q    <= '0;
            misr_q    <= '0;
            pat_cnt_q <= '0;
            num_pat_q <= '0;
            golden_q  <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            misr_q    <= misr_d;
            pat_cnt_q <= pat_cnt_d;
            num_pat_q <= num_pat_d;
            golden_q  <= golden_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (num_pat == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (adv && last) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lfsr_d    = lfsr_q;
        misr_d    = misr_q;
        pat_cnt_d = pat_cnt_q;
        num_pat_d = num_pat_q;
        golden_d  = golden_q;
        if (load) begin
            lfsr_d    = SEED_EFF;
            misr_d    = '0;
            pat_cnt_d = '0;
            num_pat_d = num_pat;
            golden_d  = golden;
        end else if (state_q == S_RUN && adv) begin
            lfsr_d    = lfsr_step(lfsr_q);
            misr_d    = misr_step(misr_q) ^ dut_out;
            pat_cnt_d = pat_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        busy      = (state_q == S_RUN);
        done      = (state_q == S_DONE);
        dut_in    = busy ? lfsr_q : '0;
        signature = misr_q;
        pass      = done && (misr_q == golden_q);
        pat_cnt   = pat_cnt_q;
    end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Scoreboard bench for gate_bist_ctrl against a loop-based signature model.
// Build with GATE_BIST_HOLD_EN to also exercise the hold input.
module tb_gate_bist_ctrl;

    localparam logic [21:0] POLY  = 22'h300000;
    localparam logic [9:0]  MPOLY = 10'h240;
    localparam logic [21:0] SEED  = 22'h1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        hold;
    logic [15:0] num_pat;
    logic [9:0]  golden;
    logic [21:0] dut_in;
    logic [9:0]  dut_out;
    logic        busy;
    logic        done;
    logic [9:0]  signature;
    logic        pass;
    logic [15:0] pat_cnt;

    int mode = 0;
    int total = 0;
    int passed = 0;
    int bcnt = 0;
    int busy_raw = 0;
    bit hold_rnd = 0;

    typedef struct {
        logic [9:0]  sig;
        logic        pass;
        logic [15:0] cnt;
        int          nbusy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    function automatic logic [9:0] gate_model(input int md, input logic [21:0] x);
        case (md)
            1: return 10'h3FF;
            2: return 10'h000;
            default: return x[9:0] ^ x[21:12] ^ {x[10], x[11], x[19:12]};
        endcase
    endfunction

    assign dut_out = gate_model(mode, dut_in);

    gate_bist_ctrl dut (
        .clk(clk),
        .rst(rst),
        .start(start),
`ifdef GATE_BIST_HOLD_EN
        .hold(hold),
`endif
        .num_pat(num_pat),
        .golden(golden),
        .dut_in(dut_in),
        .dut_out(dut_out),
        .busy(busy),
        .done(done),
        .signature(signature),
        .pass(pass),
        .pat_cnt(pat_cnt)
    );

    function automatic exp_t model(input int n, input logic [9:0] g, input int md);
        exp_t r;
        logic [21:0] l;
        logic [9:0] m;
        l = (SEED == 0) ? 22'h1 : SEED;
        m = '0;
        for (int i = 0; i < n; i++) begin
            m = (m[0] ? ((m >> 1) ^ MPOLY) : (m >> 1)) ^ gate_model(md, l);
            l = l[0] ? ((l >> 1) ^ POLY) : (l >> 1);
        end
        r.sig = m;
        r.pass = (m == g);
        r.cnt = 16'(n);
        r.nbusy = n;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) if (rst) bcnt = 0;

    always @(negedge clk) begin
        if (busy) busy_raw++;
        if (!rst) begin
            if (busy && !hold) bcnt++;
            if (done && sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("signature", 32'(signature), 32'(mon_e.sig));
                check("pass", 32'(pass), 32'(mon_e.pass));
                check("pat_cnt", 32'(pat_cnt), 32'(mon_e.cnt));
                check("advance_cycles", bcnt, mon_e.nbusy);
                check("dut_in_done", 32'(dut_in), 32'h0);
                bcnt = 0;
            end
        end
    end

`ifdef GATE_BIST_HOLD_EN
    always @(posedge clk) begin
        if (hold_rnd) begin
            #1 hold = ($urandom % 3 == 0);
        end
    end
`endif

    task automatic do_start(input int n, input logic [9:0] g, input bit push);
        exp_t e;
        start = 1'b1;
        num_pat = 16'(n);
        golden = g;
        @(posedge clk);
        if (push) begin
            e = model(n, g, mode);
            sb.push_back(e);
        end
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while (sb.size() > 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() > 0) begin
            total++;
            $display("FAIL timeout: got pending=%0d expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int n;
        logic [9:0] g;
        rst = 1'b1;
        start = 1'b0;
        hold = 1'b0;
        num_pat = '0;
        golden = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_dut_in", 32'(dut_in), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sig", 32'(signature), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_cnt", 32'(pat_cnt), 0);
        @(posedge clk);
        #1;

        mode = 1;
        busy_raw = 0;
        do_start(2, 10'h040, 1);
        @(negedge clk);
        check("pat1", 32'(dut_in), 32'h000001);
        @(negedge clk);
        check("pat2", 32'(dut_in), 32'h300000);
        wait_idle(10);
        check("busy_len2", busy_raw, 2);

        do_start(1, 10'h000, 1);
        wait_idle(10);

        mode = 2;
        do_start(1000, 10'h000, 1);
        wait_idle(1100);

        busy_raw = 0;
        do_start(0, 10'h000, 1);
        wait_idle(5);
        do_start(0, 10'h155, 1);
        wait_idle(5);
        check("busy_np0", busy_raw, 0);

        mode = 0;
        do_start(20, 10'h000, 0);
        repeat (5) @(negedge clk);
        check("mid_cnt", 32'(pat_cnt), 4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        num_pat = 16'd7;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("mrst_dut_in", 32'(dut_in), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_done", 32'(done), 0);
        check("mrst_sig", 32'(signature), 0);
        check("mrst_cnt", 32'(pat_cnt), 0);
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        @(posedge clk);
        #1;

        do_start(10, 10'h2A5, 1);
        @(posedge clk);
        #1;
        start = 1'b1;
        num_pat = 16'd3;
        golden = 10'h111;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(30);

        check("in_done", 32'(done), 1);
        do_start(5, 10'h000, 1);
        @(negedge clk);
        check("restart_seed", 32'(dut_in), 32'(SEED));
        wait_idle(20);

        for (int i = 0; i < 24; i++) begin
            mode = ($urandom % 4 == 0) ? int'($urandom_range(1, 2)) : 0;
            n = $urandom_range(0, 40);
            g = 10'($urandom);
            e = model(n, g, mode);
            if ($urandom % 2 == 0) g = e.sig;
            do_start(n, g, 1);
            wait_idle(n + 20);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

`ifdef GATE_BIST_HOLD_EN
        mode = 0;
        busy_raw = 0;
        do_start(4, 10'h000, 1);
        @(posedge clk);
        #1 hold = 1'b1;
        repeat (3) @(posedge clk);
        #1 hold = 1'b0;
        wait_idle(20);
        check("hold_busy_len", busy_raw, 7);

        hold_rnd = 1;
        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(1, 30);
            g = 10'($urandom);
            do_start(n, g, 1);
            wait_idle(4 * n + 20);
        end
        hold_rnd = 0;
        @(posedge clk);
        #2 hold = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
